conv_1d_mac_sequencer: RTL and testbench
========================================

Name: conv_1d_mac_sequencer

Overview:
- Control/data-feed front end for the 4-lane 1D convolution MAC array.
- Holds one input signal and four kernels in local storage.
- For each output position, drives clear/valid and w/x operands into the four MAC lanes, then captures the four 16-bit partial sums.
- Presents each captured result set on a valid/ready output port.

Parameters:
- KERNEL_LEN, 3, taps per kernel (K); all four kernels have the same length.
- SIG_LEN, 16, input signal samples (N).
- Derived, not overridable: OUT_LEN = N-K+1 (14 by default); XAW = $clog2(N) (4); WAW = $clog2(K) (2); IAW = $clog2(OUT_LEN) (4).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- x_wr_en  in  1  write one signal sample
- x_wr_addr  in  XAW  sample index
- x_wr_data  in  8  signed sample
- w_wr_en  in  1  write one kernel tap
- w_wr_sel  in  2  kernel select, 0..3 maps to lanes 1..4
- w_wr_addr  in  WAW  tap index
- w_wr_data  in  8  signed tap
- start  in  1  begin a convolution pass
- busy  out  1  high from start accept until return to IDLE
- done  out  1  one-cycle pulse when the pass completes
- mac_clear  out  1  clears all MAC lanes
- mac_valid  out  1  accumulate enable for all lanes
- w_out_1..w_out_4  out  8 each  signed weight per lane
- x_out_1..x_out_4  out  8 each  signed sample per lane (identical value on all four)
- mac_in_1..mac_in_4  in  16 each  signed partial sums from the lanes
- res_valid  out  1  result set available
- res_ready  in  1  consumer accepts
- res_index  out  IAW  output position of the current result
- res_1..res_4  out  16 each  signed result per kernel

Behaviour:
- Clocking and reset:
  - Single clock `clk`; reset `reset_n` is synchronous, active-low.
  - On reset, all outputs are 0, the FSM enters IDLE, and the position/tap counters are 0.
  - Sample and kernel storage is not reset; its contents are retained.
- MAC lane contract:
  - mac_clear zeroes a lane's accumulator at the clock edge.
  - mac_valid adds w*x at the clock edge.
  - The updated sum is visible on mac_in_* in the following cycle.
- Storage writes:
  - Writes take effect at the clock edge when the FSM is in IDLE.
  - Writes while busy=1 are ignored.
  - Out-of-range addresses (x_wr_addr ≥ N, w_wr_addr ≥ K) are ignored.
- FSM states: IDLE, CLEAR, FEED, DRAIN, OUT.
  - IDLE: start=1 → CLEAR, with pos=0 and busy=1.
  - CLEAR (1 cycle): mac_clear=1 → FEED, with tap=0.
  - FEED (K cycles): mac_valid=1; w_out_L = kernel[L][tap]; x_out_* = x[pos+tap]. After tap=K-1, go to DRAIN.
  - DRAIN (1 cycle): mac_clear=0 and mac_valid=0. At the end of the cycle, register mac_in_1..4 into res_1..4 and pos into res_index; set res_valid=1 → OUT.
  - OUT: hold res_* and res_index stable while res_ready=0.
    - On res_valid & res_ready with pos < OUT_LEN-1: clear res_valid, pos+1 → CLEAR.
    - On res_valid & res_ready with pos = OUT_LEN-1: clear res_valid, pulse done=1 for one cycle, busy=0 → IDLE.
- Operand outputs: w_out_* and x_out_* are 0 outside FEED; mac_valid and mac_clear are never high together.
- Timing:
  - Start accepted at edge 0 gives mac_clear in cycle 1, mac_valid in cycles 2..K+1, DRAIN in cycle K+2, and res_valid first high in cycle K+3.
  - With res_ready held high, each output takes K+3 cycles; a full pass takes OUT_LEN*(K+3) cycles.
- Start handling: start while busy=1 is ignored; start on the same edge as done returns the FSM to IDLE first and is not accepted.
- Arithmetic: the sequencer does no arithmetic on the sums; overflow wraps in the 16-bit MAC lanes and is passed through unchanged.
- Reset mid-operation: reset_n=0 in any state forces IDLE and zeroes busy, done, res_valid, mac_* and the operand outputs in the next cycle. No done pulse is issued for the aborted pass.

Test Plan:
1. Reset: hold reset_n=0 for 2 cycles with random inputs → all outputs 0 and busy=0; a write then a read-back via a pass shows the stored values.
2. Basic pass:
   - Setup: x=1..16, k1={1,1,1}, k2={1,0,-1}, k3={2,0,0}, k4={0,0,1}, res_ready=1.
   - Index 0: res_1=6, res_2=-2, res_3=2, res_4=3.
   - Index 13: res_1=45, res_2=-2, res_3=28, res_4=16.
   - Exactly 14 result handshakes, then done=1 for one cycle.
3. Timing: start at edge 0 → mac_clear only in cycle 1, mac_valid in cycles 2–4, res_valid in cycle 6; done asserted at cycle 84±1 with res_ready=1.
4. Backpressure: drop res_ready for 10 cycles at index 2 → res_valid stays 1, res_* and res_index stay constant, mac_clear and mac_valid stay 0, and no index is skipped or duplicated.
5. Ignored events and overflow:
   - start pulsed mid-pass and x_wr_en while busy → no effect on results or stored data.
   - All taps and samples = -128 → each res = 0xC000 (49152 wrapped).
6. Mid-pass reset: reset_n=0 during FEED at index 5 → IDLE next cycle with all outputs 0 and no done; a restart yields index 0 results identical to scenario 2.

Source files
------------

// File: rtl/conv_1d_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conv_1d_mac_sequencer
// Purpose  : Feeds stored samples and four kernels into a 4-lane MAC array and
//            returns one result set per output position over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module conv_1d_mac_sequencer #(
  parameter  int KERNEL_LEN = 3,
  parameter  int SIG_LEN    = 16,
  localparam int OUT_LEN    = SIG_LEN - KERNEL_LEN + 1,
  localparam int XAW        = $clog2(SIG_LEN),
  localparam int WAW        = $clog2(KERNEL_LEN),
  localparam int IAW        = $clog2(OUT_LEN)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            x_wr_en,
  input  logic [XAW-1:0]  x_wr_addr,
  input  logic [7:0]      x_wr_data,
  input  logic            w_wr_en,
  input  logic [1:0]      w_wr_sel,
  input  logic [WAW-1:0]  w_wr_addr,
  input  logic [7:0]      w_wr_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            mac_clear,
  output logic            mac_valid,
  output logic [7:0]      w_out_1,
  output logic [7:0]      w_out_2,
  output logic [7:0]      w_out_3,
  output logic [7:0]      w_out_4,
  output logic [7:0]      x_out_1,
  output logic [7:0]      x_out_2,
  output logic [7:0]      x_out_3,
  output logic [7:0]      x_out_4,
  input  logic [15:0]     mac_in_1,
  input  logic [15:0]     mac_in_2,
  input  logic [15:0]     mac_in_3,
  input  logic [15:0]     mac_in_4,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [IAW-1:0]  res_index,
  output logic [15:0]     res_1,
  output logic [15:0]     res_2,
  output logic [15:0]     res_3,
  output logic [15:0]     res_4
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IAW-1:0]  r_pos;
  logic [WAW-1:0]  r_tap;
  logic            r_res_valid;
  logic            r_done;
  logic [IAW-1:0]  r_res_index;
  logic [15:0]     r_res_1, r_res_2, r_res_3, r_res_4;

  logic [7:0]      r_x [SIG_LEN];
  logic [7:0]      r_k [4][KERNEL_LEN];

  logic            w_idle;
  logic            w_x_ok;
  logic            w_w_ok;
  logic            w_last_tap;
  logic            w_last_pos;
  logic            w_hs;
  logic [XAW-1:0]  w_xidx;
  logic [7:0]      w_xval;

  assign w_idle     = (r_state == S_IDLE);
  assign w_last_tap = (r_tap == WAW'(KERNEL_LEN - 1));
  assign w_last_pos = (r_pos == IAW'(OUT_LEN - 1));
  assign w_hs       = r_res_valid & res_ready;
  assign w_xidx     = XAW'(r_pos) + XAW'(r_tap);
  assign w_xval     = r_x[w_xidx];

  // A full-range address field needs no bound check (and would make a constant compare).
  generate
    if (SIG_LEN == (1 << XAW)) begin : g_x_full
      assign w_x_ok = 1'b1;
    end else begin : g_x_part
      assign w_x_ok = (x_wr_addr < XAW'(SIG_LEN));
    end
    if (KERNEL_LEN == (1 << WAW)) begin : g_w_full
      assign w_w_ok = 1'b1;
    end else begin : g_w_part
      assign w_w_ok = (w_wr_addr < WAW'(KERNEL_LEN));
    end
  endgenerate

  // Storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (w_idle && x_wr_en && w_x_ok)
      r_x[x_wr_addr] <= x_wr_data;
    if (w_idle && w_wr_en && w_w_ok)
      r_k[w_wr_sel][w_wr_addr] <= w_wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    mac_clear = 1'b0;
    mac_valid = 1'b0;
    w_out_1   = 8'h00;
    w_out_2   = 8'h00;
    w_out_3   = 8'h00;
    w_out_4   = 8'h00;
    x_out_1   = 8'h00;
    x_out_2   = 8'h00;
    x_out_3   = 8'h00;
    x_out_4   = 8'h00;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CLEAR;
      S_CLEAR: begin
        mac_clear = 1'b1;
        w_next    = S_FEED;
      end
      S_FEED: begin
        mac_valid = 1'b1;
        w_out_1   = r_k[0][r_tap];
        w_out_2   = r_k[1][r_tap];
        w_out_3   = r_k[2][r_tap];
        w_out_4   = r_k[3][r_tap];
        x_out_1   = w_xval;
        x_out_2   = w_xval;
        x_out_3   = w_xval;
        x_out_4   = w_xval;
        if (w_last_tap) w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_OUT;
      S_OUT:   if (w_hs) w_next = w_last_pos ? S_IDLE : S_CLEAR;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pos       <= '0;
      r_tap       <= '0;
      r_res_valid <= 1'b0;
      r_done      <= 1'b0;
      r_res_index <= '0;
      r_res_1     <= 16'h0000;
      r_res_2     <= 16'h0000;
      r_res_3     <= 16'h0000;
      r_res_4     <= 16'h0000;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE:  if (start) r_pos <= '0;
        S_CLEAR: r_tap <= '0;
        S_FEED:  r_tap <= w_last_tap ? '0 : r_tap + 1'b1;
        S_DRAIN: begin
          // The last accumulate landed at the previous edge, so mac_in_* is final here.
          r_res_1     <= mac_in_1;
          r_res_2     <= mac_in_2;
          r_res_3     <= mac_in_3;
          r_res_4     <= mac_in_4;
          r_res_index <= r_pos;
          r_res_valid <= 1'b1;
        end
        S_OUT: begin
          if (w_hs) begin
            r_res_valid <= 1'b0;
            if (w_last_pos) r_done <= 1'b1;
            else            r_pos  <= r_pos + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = ~w_idle;
  assign done      = r_done;
  assign res_valid = r_res_valid;
  assign res_index = r_res_index;
  assign res_1     = r_res_1;
  assign res_2     = r_res_2;
  assign res_3     = r_res_3;
  assign res_4     = r_res_4;

endmodule
`default_nettype wire

// File: tb/tb_conv_1d_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_1d_mac_sequencer
// Purpose  : Directed self-checking bench with a behavioural 4-lane MAC array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_1d_mac_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        x_wr_en, w_wr_en, start, res_ready;
  logic [3:0]  x_wr_addr;
  logic [7:0]  x_wr_data, w_wr_data;
  logic [1:0]  w_wr_sel, w_wr_addr;
  logic        busy, done, mac_clear, mac_valid, res_valid;
  logic [7:0]  w_out_1, w_out_2, w_out_3, w_out_4;
  logic [7:0]  x_out_1, x_out_2, x_out_3, x_out_4;
  logic [15:0] mac_in_1, mac_in_2, mac_in_3, mac_in_4;
  logic [3:0]  res_index;
  logic [15:0] res_1, res_2, res_3, res_4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  conv_1d_mac_sequencer #(.KERNEL_LEN(3), .SIG_LEN(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .x_wr_en(x_wr_en), .x_wr_addr(x_wr_addr), .x_wr_data(x_wr_data),
    .w_wr_en(w_wr_en), .w_wr_sel(w_wr_sel), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .start(start), .busy(busy), .done(done),
    .mac_clear(mac_clear), .mac_valid(mac_valid),
    .w_out_1(w_out_1), .w_out_2(w_out_2), .w_out_3(w_out_3), .w_out_4(w_out_4),
    .x_out_1(x_out_1), .x_out_2(x_out_2), .x_out_3(x_out_3), .x_out_4(x_out_4),
    .mac_in_1(mac_in_1), .mac_in_2(mac_in_2), .mac_in_3(mac_in_3), .mac_in_4(mac_in_4),
    .res_valid(res_valid), .res_ready(res_ready), .res_index(res_index),
    .res_1(res_1), .res_2(res_2), .res_3(res_3), .res_4(res_4)
  );

  // Behavioural MAC lanes: 16-bit wrapping signed accumulate.
  logic [15:0] acc [4];

  function automatic logic [15:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb;
    sa = 16'($signed(a));
    sb = 16'($signed(b));
    return 16'(sa * sb);
  endfunction

  always @(posedge clk) begin
    if (mac_clear) begin
      for (int i = 0; i < 4; i++) acc[i] <= 16'h0000;
    end else if (mac_valid) begin
      acc[0] <= acc[0] + mul(w_out_1, x_out_1);
      acc[1] <= acc[1] + mul(w_out_2, x_out_2);
      acc[2] <= acc[2] + mul(w_out_3, x_out_3);
      acc[3] <= acc[3] + mul(w_out_4, x_out_4);
    end
  end
  assign mac_in_1 = acc[0];
  assign mac_in_2 = acc[1];
  assign mac_in_3 = acc[2];
  assign mac_in_4 = acc[3];

  // Handshake recorder and protocol watchers.
  int          hs_cnt = 0, seq_err = 0, done_cnt = 0, viol = 0;
  logic [3:0]  prev_idx = 4'd0;
  logic [15:0] c1 [16], c2 [16], c3 [16], c4 [16];

  always @(negedge clk) begin
    if (reset_n && res_valid && res_ready) begin
      if (res_index != 4'd0 && res_index != prev_idx + 4'd1) seq_err <= seq_err + 1;
      prev_idx      <= res_index;
      c1[res_index] <= res_1;
      c2[res_index] <= res_2;
      c3[res_index] <= res_3;
      c4[res_index] <= res_4;
      hs_cnt        <= hs_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (mac_clear && mac_valid) viol <= viol + 1;
    if (!mac_valid && ({w_out_1, w_out_2, w_out_3, w_out_4,
                        x_out_1, x_out_2, x_out_3, x_out_4} != 64'h0)) viol <= viol + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_x(input logic [3:0] a, input logic [7:0] d);
    x_wr_en = 1'b1; x_wr_addr = a; x_wr_data = d;
    tick;
    x_wr_en = 1'b0;
  endtask

  task automatic wr_w(input logic [1:0] s, input logic [1:0] a, input logic [7:0] d);
    w_wr_en = 1'b1; w_wr_sel = s; w_wr_addr = a; w_wr_data = d;
    tick;
    w_wr_en = 1'b0;
  endtask

  task automatic load_basic;
    logic [7:0] kt [4][3];
    kt = '{'{8'd1, 8'd1, 8'd1}, '{8'd1, 8'd0, 8'hFF}, '{8'd2, 8'd0, 8'd0}, '{8'd0, 8'd0, 8'd1}};
    for (int i = 0; i < 16; i++) wr_x(4'(i), 8'(i + 1));
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 3; a++) wr_w(2'(s), 2'(a), kt[s][a]);
  endtask

  // Runs one pass with res_ready high; returns the cycle (edge 0 = start accept) done is seen.
  task automatic run_pass(input bit timing, input bit inject, output int dcyc);
    int cyc;
    res_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 1;
    if (timing) begin
      chk("t1_clear", 32'(mac_clear), 32'd1);
      chk("t1_valid", 32'(mac_valid), 32'd0);
      chk("t1_busy",  32'(busy), 32'd1);
      tick; cyc++;
      chk("t2_w2", 32'(w_out_2), 32'h01);
      chk("t2_x1", 32'(x_out_1), 32'h01);
      for (int c = 2; c <= 4; c++) begin
        chk("t_feed_valid", 32'(mac_valid), 32'd1);
        chk("t_feed_clear", 32'(mac_clear), 32'd0);
        if (c == 4) begin
          chk("t4_w2", 32'(w_out_2), 32'hFF);
          chk("t4_x3", 32'(x_out_3), 32'h03);
        end
        tick; cyc++;
      end
      chk("t5_valid", 32'(mac_valid), 32'd0);
      chk("t5_rv",    32'(res_valid), 32'd0);
      tick; cyc++;
      chk("t6_rv",    32'(res_valid), 32'd1);
    end
    while (!done && cyc < 400) begin
      if (inject && cyc == 20) begin
        start = 1'b1; x_wr_en = 1'b1; x_wr_addr = 4'd13; x_wr_data = 8'd100;
      end
      tick; cyc++;
      start = 1'b0; x_wr_en = 1'b0;
    end
    dcyc = done ? cyc : -1;
    if (!done) chk("pass_timeout", 32'd0, 32'd1);
  endtask

  int dcyc, base, dc0, k;
  bit ok;
  logic [15:0] s1, s2, s3, s4;
  logic [3:0]  si;
  int hold_err;

  initial begin
    // Reset with random inputs
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      x_wr_en = 1'($urandom); x_wr_addr = 4'($urandom); x_wr_data = 8'($urandom);
      w_wr_en = 1'($urandom); w_wr_sel = 2'($urandom); w_wr_addr = 2'($urandom);
      w_wr_data = 8'($urandom); start = 1'($urandom); res_ready = 1'($urandom);
      tick;
    end
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ctl",  32'({done, mac_clear, mac_valid, res_valid}), 32'd0);
    chk("rst_ops",  32'({w_out_1, w_out_4, x_out_1, x_out_4}), 32'd0);
    chk("rst_res",  32'({res_1, res_4}), 32'd0);
    chk("rst_idx",  32'(res_index), 32'd0);
    x_wr_en = 1'b0; w_wr_en = 1'b0; start = 1'b0; res_ready = 1'b1;
    reset_n = 1'b1;
    tick;

    // Basic pass with timing, mid-pass start/write, and an out-of-range tap write
    load_basic;
    wr_w(2'd0, 2'd3, 8'h7F);
    base = hs_cnt; dc0 = done_cnt;
    run_pass(1'b1, 1'b1, dcyc);
    chk("done_cycle_ok", 32'((dcyc >= 83) && (dcyc <= 85)), 32'd1);
    chk("hs_count", 32'(hs_cnt - base), 32'd14);
    chk("seq_err", 32'(seq_err), 32'd0);
    chk("i0_r1",  32'(c1[0]),  32'd6);
    chk("i0_r2",  32'(c2[0]),  32'hFFFE);
    chk("i0_r3",  32'(c3[0]),  32'd2);
    chk("i0_r4",  32'(c4[0]),  32'd3);
    chk("i13_r1", 32'(c1[13]), 32'd45);
    chk("i13_r2", 32'(c2[13]), 32'hFFFE);
    chk("i13_r3", 32'(c3[13]), 32'd28);
    chk("i13_r4", 32'(c4[13]), 32'd16);
    chk("busy_at_done", 32'(busy), 32'd0);
    tick;
    chk("done_width", 32'(done), 32'd0);
    chk("done_count", 32'(done_cnt - dc0), 32'd1);

    // Backpressure: 10 stalled cycles at index 2
    base = hs_cnt; dc0 = done_cnt; hold_err = 0;
    res_ready = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    for (int n = 0; n < 14; n++) begin
      ok = 1'b0;
      for (int w = 0; w < 20 && !ok; w++) begin
        if (res_valid) ok = 1'b1;
        else tick;
      end
      if (!ok) begin
        chk("bp_wait_rv", 32'd0, 32'd1);
        break;
      end
      if (res_index == 4'd2) begin
        s1 = res_1; s2 = res_2; s3 = res_3; s4 = res_4; si = res_index;
        for (int h = 0; h < 10; h++) begin
          tick;
          if (!res_valid || mac_clear || mac_valid || res_index != si ||
              {res_1, res_2, res_3, res_4} != {s1, s2, s3, s4}) hold_err++;
        end
        chk("bp_r1", 32'(res_1), 32'd12);
        chk("bp_r2", 32'(res_2), 32'hFFFE);
        chk("bp_r4", 32'(res_4), 32'd5);
      end
      res_ready = 1'b1;
      tick;
      res_ready = 1'b0;
    end
    k = 0;
    while (!done && k < 20) begin tick; k++; end
    chk("bp_done", 32'(done), 32'd1);
    chk("bp_hold", 32'(hold_err), 32'd0);
    chk("bp_hs", 32'(hs_cnt - base), 32'd14);
    chk("bp_seq", 32'(seq_err), 32'd0);
    chk("bp_i2_r3", 32'(c3[2]), 32'd6);
    res_ready = 1'b1;
    tick;

    // Mid-pass reset during FEED of index 5
    base = hs_cnt;
    start = 1'b1; tick; start = 1'b0;
    k = 0;
    while ((hs_cnt - base) < 5 && k < 100) begin tick; k++; end
    tick;
    chk("mr_in_feed", 32'(mac_valid), 32'd1);
    dc0 = done_cnt;
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_ctl",  32'({done, mac_clear, mac_valid, res_valid}), 32'd0);
    chk("mr_ops",  32'({w_out_1, w_out_3, x_out_2}), 32'd0);
    for (int i = 0; i < 5; i++) tick;
    chk("mr_no_done", 32'(done_cnt - dc0), 32'd0);
    run_pass(1'b0, 1'b0, dcyc);
    chk("mr_i0_r1", 32'(c1[0]), 32'd6);
    chk("mr_i0_r2", 32'(c2[0]), 32'hFFFE);
    chk("mr_i0_r3", 32'(c3[0]), 32'd2);
    chk("mr_i0_r4", 32'(c4[0]), 32'd3);
    tick;

    // Overflow: every tap and sample -128
    for (int i = 0; i < 16; i++) wr_x(4'(i), 8'h80);
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 3; a++) wr_w(2'(s), 2'(a), 8'h80);
    run_pass(1'b0, 1'b0, dcyc);
    chk("ov_i0_r1",  32'(c1[0]),  32'hC000);
    chk("ov_i5_r2",  32'(c2[5]),  32'hC000);
    chk("ov_i9_r3",  32'(c3[9]),  32'hC000);
    chk("ov_i13_r4", 32'(c4[13]), 32'hC000);

    tick;
    chk("protocol_viol", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
